// File: rtl/key_pkg.sv
// Shared types and default timing for the single-key event controller.
// Used by key_event_ctrl; the optional double-click feature is KEY_DOUBLE_CLICK_EN.
package key_pkg;

  localparam int CNT_W = 26;

  localparam logic [CNT_W-1:0] CNT_DEB_DEF  = 26'd999_999;
  localparam logic [CNT_W-1:0] CNT_LONG_DEF = 26'd49_999_999;
  localparam logic [CNT_W-1:0] CNT_DBL_DEF  = 26'd14_999_999;
  localparam logic [CNT_W-1:0] CNT_ONE      = 26'd1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_DN    = 3'd1,
    PRESSED   = 3'd2,
    LONG_HELD = 3'd3,
    DEB_UP    = 3'd4,
    WAIT_DBL  = 3'd5
  } key_state_e;

  // The hold level covers the release debounce so a bouncing release never drops it.
  function automatic logic is_hold(input key_state_e st);
    return (st == PRESSED) || (st == LONG_HELD) || (st == DEB_UP);
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the raw key pin; resets to the released level (1).
module key_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/key_event_ctrl.sv
// Single-key debounce and press classifier (short / long / optional double click).
// Double-click detection is enabled by defining KEY_DOUBLE_CLICK_EN.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_DEB  = CNT_DEB_DEF,
  parameter logic [CNT_W-1:0] CNT_LONG = CNT_LONG_DEF,
  parameter logic [CNT_W-1:0] CNT_DBL  = CNT_DBL_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_hold,
  output logic key_short,
  output logic key_long,
  output logic key_double
);

  if ((CNT_DEB < 2) || (CNT_LONG < 2) || (CNT_DBL < 2)) begin : g_bad_cfg
    $error("key_event_ctrl: every CNT_* must be at least 2");
  end

  logic       w_key_s;
  key_state_e r_state;
  key_state_e w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic       w_timed;
  logic       r_was_long;
  logic       w_was_long_nxt;
  logic       r_short;
  logic       w_short_nxt;
  logic       r_long;
  logic       w_long_nxt;
`ifdef KEY_DOUBLE_CLICK_EN
  logic       r_second;
  logic       w_second_nxt;
  logic       r_double;
  logic       w_double_nxt;
`endif

  key_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_d       (key_in),
    .o_q       (w_key_s)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_was_long <= 1'b0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
`ifdef KEY_DOUBLE_CLICK_EN
      r_second   <= 1'b0;
      r_double   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_was_long <= w_was_long_nxt;
      r_short    <= w_short_nxt;
      r_long     <= w_long_nxt;
`ifdef KEY_DOUBLE_CLICK_EN
      r_second   <= w_second_nxt;
      r_double   <= w_double_nxt;
`endif
    end
  end

  assign w_timed = (r_state == DEB_DN) || (r_state == PRESSED) ||
                   (r_state == DEB_UP) || (r_state == WAIT_DBL);

  // One timer serves every window: it restarts on any state change and saturates.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (w_timed && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_was_long_nxt = r_was_long;
    w_short_nxt    = 1'b0;
    w_long_nxt     = 1'b0;
`ifdef KEY_DOUBLE_CLICK_EN
    w_second_nxt   = r_second;
    w_double_nxt   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_key_s) w_state_nxt = DEB_DN;
      end
      DEB_DN: begin
        if (w_key_s) begin
          w_state_nxt = IDLE;
`ifdef KEY_DOUBLE_CLICK_EN
          // A bounced second press still owes the first click its short pulse.
          if (r_second) begin
            w_short_nxt  = 1'b1;
            w_second_nxt = 1'b0;
          end
`endif
        end else if (r_cnt == CNT_DEB) begin
          w_state_nxt    = PRESSED;
          w_was_long_nxt = 1'b0;
        end
      end
      PRESSED: begin
        if (w_key_s) begin
          w_state_nxt = DEB_UP;
        end else if (r_cnt == CNT_LONG) begin
          w_state_nxt    = LONG_HELD;
          w_long_nxt     = 1'b1;
          w_was_long_nxt = 1'b1;
        end
      end
      LONG_HELD: begin
        if (w_key_s) w_state_nxt = DEB_UP;
      end
      DEB_UP: begin
        if (!w_key_s) begin
          w_state_nxt = r_was_long ? LONG_HELD : PRESSED;
        end else if (r_cnt == CNT_DEB) begin
          w_state_nxt = IDLE;
          if (r_was_long) begin
`ifdef KEY_DOUBLE_CLICK_EN
            w_second_nxt = 1'b0;
`endif
          end else begin
`ifdef KEY_DOUBLE_CLICK_EN
            if (r_second) begin
              w_double_nxt = 1'b1;
              w_second_nxt = 1'b0;
            end else begin
              w_state_nxt = WAIT_DBL;
            end
`else
            w_short_nxt = 1'b1;
`endif
          end
        end
      end
`ifdef KEY_DOUBLE_CLICK_EN
      WAIT_DBL: begin
        if (!w_key_s) begin
          w_state_nxt  = DEB_DN;
          w_second_nxt = 1'b1;
        end else if (r_cnt == CNT_DBL) begin
          w_state_nxt = IDLE;
          w_short_nxt = 1'b1;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  assign key_hold  = is_hold(r_state);
  assign key_short = r_short;
  assign key_long  = r_long;
`ifdef KEY_DOUBLE_CLICK_EN
  assign key_double = r_double;
`else
  assign key_double = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with short timer values (DEB=20, LONG=200, DBL=100).
module tb_key_event_ctrl;

`ifdef KEY_DOUBLE_CLICK_EN
  localparam int SHORT_LAT = 125;
`else
  localparam int SHORT_LAT = 24;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_hold, key_short, key_long, key_double;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_short = 0, n_long = 0, n_double = 0, n_rise = 0;
  int t_short = -1, t_long = -1, t_double = -1, t_rise = -1, t_fall = -1;
  logic hold_q = 1'b0;

  key_event_ctrl #(.CNT_DEB(26'd20), .CNT_LONG(26'd200), .CNT_DBL(26'd100)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_hold   (key_hold),
    .key_short  (key_short),
    .key_long   (key_long),
    .key_double (key_double)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (key_short)  begin n_short  <= n_short + 1;  t_short  <= cyc; end
    if (key_long)   begin n_long   <= n_long + 1;   t_long   <= cyc; end
    if (key_double) begin n_double <= n_double + 1; t_double <= cyc; end
    if (key_hold && !hold_q) begin n_rise <= n_rise + 1; t_rise <= cyc; end
    if (!key_hold && hold_q) t_fall <= cyc;
    hold_q <= key_hold;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (key_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b exp 0", key_hold); end
    checks++; if ({key_short, key_long, key_double} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {key_short, key_long, key_double}); end
    sys_rst_n = 1'b1;
    tick(10);
    checks++; if (key_hold !== 1'b0) begin errors++; $display("FAIL idle_hold got %b exp 0", key_hold); end
    checks++; if (n_short + n_long + n_double !== 0) begin errors++; $display("FAIL idle_pulses got %0d exp 0", n_short + n_long + n_double); end
  endtask

  task automatic test_bounce;
    int r0, p0;
    r0 = n_rise; p0 = n_short + n_long + n_double;
    key_in = 1'b0; tick(5);
    key_in = 1'b1; tick(40);
    checks++; if (n_rise !== r0) begin errors++; $display("FAIL bounce_hold_rises got %0d exp %0d", n_rise, r0); end
    checks++; if (n_short + n_long + n_double !== p0) begin errors++; $display("FAIL bounce_pulses got %0d exp %0d", n_short + n_long + n_double, p0); end
  endtask

  task automatic test_short_press;
    int c0, r0, s0;
    s0 = n_short;
    key_in = 1'b0; c0 = cyc;
    tick(100);
    key_in = 1'b1; r0 = cyc;
    tick(200);
    checks++; if (t_rise !== c0 + 24) begin errors++; $display("FAIL short_hold_rise got %0d exp %0d", t_rise, c0 + 24); end
    checks++; if (t_fall !== r0 + 24) begin errors++; $display("FAIL short_hold_fall got %0d exp %0d", t_fall, r0 + 24); end
    checks++; if (n_short !== s0 + 1) begin errors++; $display("FAIL short_count got %0d exp %0d", n_short, s0 + 1); end
    checks++; if (t_short !== r0 + SHORT_LAT) begin errors++; $display("FAIL short_time got %0d exp %0d", t_short, r0 + SHORT_LAT); end
  endtask

  task automatic test_long_press;
    int c0, s0, l0;
    s0 = n_short; l0 = n_long;
    key_in = 1'b0; c0 = cyc;
    tick(400);
    key_in = 1'b1;
    tick(250);
    checks++; if (n_long !== l0 + 1) begin errors++; $display("FAIL long_count got %0d exp %0d", n_long, l0 + 1); end
    checks++; if (t_long !== c0 + 225) begin errors++; $display("FAIL long_time got %0d exp %0d", t_long, c0 + 225); end
    checks++; if (n_short !== s0) begin errors++; $display("FAIL long_no_short got %0d exp %0d", n_short, s0); end
  endtask

  task automatic test_double_click;
    int c0, s0, d0;
    s0 = n_short; d0 = n_double;
    key_in = 1'b0; c0 = cyc;
    tick(50);  key_in = 1'b1;
    tick(40);  key_in = 1'b0;
    tick(50);  key_in = 1'b1;
    tick(250);
`ifdef KEY_DOUBLE_CLICK_EN
    checks++; if (n_double !== d0 + 1) begin errors++; $display("FAIL dbl_count got %0d exp %0d", n_double, d0 + 1); end
    checks++; if (t_double !== c0 + 164) begin errors++; $display("FAIL dbl_time got %0d exp %0d", t_double, c0 + 164); end
    checks++; if (n_short !== s0) begin errors++; $display("FAIL dbl_no_short got %0d exp %0d", n_short, s0); end
`else
    checks++; if (n_double !== d0) begin errors++; $display("FAIL dbl_tied_low got %0d exp %0d", n_double, d0); end
    checks++; if (n_short !== s0 + 2) begin errors++; $display("FAIL two_shorts got %0d exp %0d", n_short, s0 + 2); end
    checks++; if (t_short !== c0 + 164) begin errors++; $display("FAIL second_short_time got %0d exp %0d", t_short, c0 + 164); end
`endif
  endtask

  task automatic test_bounce_press;
    int cs, s0, l0, r0;
    s0 = n_short; l0 = n_long; r0 = n_rise;
    for (int i = 0; i < 3; i++) begin
      key_in = 1'b0; tick(4);
      key_in = 1'b1; tick(4);
    end
    key_in = 1'b0; cs = cyc;
    tick(100);
    for (int i = 0; i < 3; i++) begin
      key_in = 1'b1; tick(4);
      key_in = 1'b0; tick(4);
    end
    key_in = 1'b1;
    tick(250);
    checks++; if (n_rise !== r0 + 1) begin errors++; $display("FAIL bnc_hold_rises got %0d exp %0d", n_rise, r0 + 1); end
    checks++; if (t_rise !== cs + 24) begin errors++; $display("FAIL bnc_hold_rise_time got %0d exp %0d", t_rise, cs + 24); end
    checks++; if (n_short !== s0 + 1) begin errors++; $display("FAIL bnc_short_count got %0d exp %0d", n_short, s0 + 1); end
    checks++; if (n_long !== l0) begin errors++; $display("FAIL bnc_no_long got %0d exp %0d", n_long, l0); end
  endtask

  task automatic test_reset_mid_hold;
    int t0, l0, s0;
    key_in = 1'b0;
    tick(100);
    checks++; if (key_hold !== 1'b1) begin errors++; $display("FAIL pre_reset_hold got %b exp 1", key_hold); end
    sys_rst_n = 1'b0;
    #1;
    checks++; if (key_hold !== 1'b0) begin errors++; $display("FAIL async_reset_hold got %b exp 0", key_hold); end
    checks++; if ({key_short, key_long, key_double} !== 3'b000) begin errors++; $display("FAIL async_reset_pulses got %b exp 000", {key_short, key_long, key_double}); end
    tick(2);
    sys_rst_n = 1'b1; t0 = cyc;
    l0 = n_long; s0 = n_short;
    tick(23);
    checks++; if (key_hold !== 1'b0) begin errors++; $display("FAIL rst_hold_early got %b exp 0", key_hold); end
    tick(200);
    checks++; if (t_rise !== t0 + 24) begin errors++; $display("FAIL rst_hold_rise got %0d exp %0d", t_rise, t0 + 24); end
    checks++; if (n_long !== l0) begin errors++; $display("FAIL rst_long_early got %0d exp %0d", n_long, l0); end
    tick(10);
    checks++; if (t_long !== t0 + 225) begin errors++; $display("FAIL rst_long_time got %0d exp %0d", t_long, t0 + 225); end
    key_in = 1'b1;
    tick(250);
    checks++; if (n_short !== s0) begin errors++; $display("FAIL rst_no_short got %0d exp %0d", n_short, s0); end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_short_press;
    test_long_press;
    test_double_click;
    test_bounce_press;
    test_reset_mid_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
